// File: rtl/mem_copy_engine.sv
// Word-granular memory copy engine: streams len words from src_base to dst_base
// through a credit-controlled read-data FIFO so write back-pressure never drops data.
module mem_copy_engine #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_LAT   = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_base,
   input  logic [ADDR_WIDTH-1:0] dst_base,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic                  r_avalid,
   input  logic                  r_aready,
   input  logic                  r_dvalid,
   input  logic [DATA_WIDTH-1:0] r_data,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic                  w_valid,
   input  logic                  w_ready
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int LW = ADDR_WIDTH + 1;

   generate
      if (DATA_LAT < 1 || FIFO_DEPTH < DATA_LAT + 1) begin : g_bad_cfg
         $error("mem_copy_engine: FIFO_DEPTH must be at least DATA_LAT+1 and DATA_LAT at least 1");
      end
   endgenerate

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state_q, state_d;
   logic                  done_q, done_d, load;
   logic [ADDR_WIDTH-1:0] src_q, dst_q;
   logic [LW-1:0]         len_q, rd_cnt, wr_cnt;
   logic [CW-1:0]         outst, fcnt;
   logic [PW-1:0]         wptr, rptr;
   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic                  rd_acc, wr_acc, push, last_wr, credit_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Reads in flight plus buffered words may never exceed the buffer depth,
   // so every returning word is guaranteed a slot.
   assign credit_ok = ({1'b0, outst} + {1'b0, fcnt}) < (CW + 1)'(FIFO_DEPTH);
   assign r_avalid  = (state_q == RUN) && (rd_cnt < len_q) && credit_ok;
   assign r_addr    = src_q + rd_cnt[ADDR_WIDTH-1:0];
   assign w_valid   = (state_q == RUN) && (fcnt != '0);
   assign w_addr    = dst_q + wr_cnt[ADDR_WIDTH-1:0];
   assign w_data    = w_valid ? fifo_mem[rptr] : '0;
   assign rd_acc    = r_avalid && r_aready;
   assign wr_acc    = w_valid && w_ready;
   assign push      = r_dvalid && (outst != '0);
   assign last_wr   = wr_acc && ((wr_cnt + LW'(1)) == len_q);
   assign busy      = (state_q == RUN);
   assign done      = done_q;

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  state_d = RUN;
                  load    = 1'b1;
               end else begin
                  done_d  = 1'b1;
               end
            end
         end
         RUN: begin
            if (last_wr) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q  <= '0;
         dst_q  <= '0;
         len_q  <= '0;
         rd_cnt <= '0;
         wr_cnt <= '0;
         outst  <= '0;
         fcnt   <= '0;
         wptr   <= '0;
         rptr   <= '0;
      end else begin
         if (load) begin
            src_q  <= src_base;
            dst_q  <= dst_base;
            len_q  <= len;
            rd_cnt <= '0;
            wr_cnt <= '0;
         end else begin
            if (rd_acc) rd_cnt <= rd_cnt + LW'(1);
            if (wr_acc) wr_cnt <= wr_cnt + LW'(1);
         end
         case ({rd_acc, push})
            2'b10:   outst <= outst + CW'(1);
            2'b01:   outst <= outst - CW'(1);
            default: outst <= outst;
         endcase
         case ({push, wr_acc})
            2'b10:   fcnt <= fcnt + CW'(1);
            2'b01:   fcnt <= fcnt - CW'(1);
            default: fcnt <= fcnt;
         endcase
         if (push)   wptr <= ptr_inc(wptr);
         if (wr_acc) rptr <= ptr_inc(rptr);
      end
   end

   // Storage needs no reset: w_data is masked whenever the buffer is empty.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wptr] <= r_data;
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: random and directed copies against a read-only
// source image and a plain arithmetic model of the expected access streams.
module tb_mem_copy_engine;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int DL = 1;
   localparam int FD = 4;
   localparam int NW = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] src_base = '0;
   logic [AW-1:0] dst_base = '0;
   logic [AW:0]   len = '0;
   logic          busy, done, r_avalid, w_valid, r_dvalid;
   logic [AW-1:0] r_addr, w_addr;
   logic [DW-1:0] w_data, r_data;
   logic          r_aready = 1'b0;
   logic          w_ready = 1'b0;

   always #5 clk = ~clk;

   mem_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_LAT(DL), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
      .len(len), .busy(busy), .done(done), .r_addr(r_addr), .r_avalid(r_avalid),
      .r_aready(r_aready), .r_dvalid(r_dvalid), .r_data(r_data), .w_addr(w_addr),
      .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready)
   );

   // Source memory with a fixed read latency; not reset, so stale data can return
   logic [DW-1:0] src_mem [NW];
   logic          dl_v [DL] = '{default: 1'b0};
   logic [DW-1:0] dl_d [DL] = '{default: '0};
   assign r_dvalid = dl_v[DL-1];
   assign r_data   = dl_d[DL-1];

   always @(posedge clk) begin
      dl_v[0] <= r_avalid && r_aready;
      dl_d[0] <= src_mem[r_addr];
      for (int i = 1; i < DL; i++) begin
         dl_v[i] <= dl_v[i-1];
         dl_d[i] <= dl_d[i-1];
      end
   end

   int            cyc = 0;
   int            start_cyc = 0;
   int            done_cyc = 0;
   int            n_done = 0;
   int            viol = 0;
   logic [AW-1:0] rd_log [$];
   logic [AW-1:0] wa_log [$];
   logic [DW-1:0] wd_log [$];
   int            wr_cyc [$];
   logic          prev_rv = 1'b0, prev_racc = 1'b0, prev_wv = 1'b0, prev_wacc = 1'b0;
   logic [AW-1:0] prev_ra = '0, prev_wa = '0;
   logic [DW-1:0] prev_wd = '0;

   // Transaction monitor: logs accepts and counts handshake-rule breaches
   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         prev_rv = 1'b0;
         prev_wv = 1'b0;
      end else begin
         if (start && !busy) start_cyc = cyc;
         if (prev_rv && !prev_racc && (!r_avalid || r_addr !== prev_ra)) viol++;
         if (prev_wv && !prev_wacc && (!w_valid || w_addr !== prev_wa || w_data !== prev_wd)) viol++;
         if (!busy && (r_avalid || w_valid)) viol++;
         if (done && busy) viol++;
         if (r_avalid && r_aready) rd_log.push_back(r_addr);
         if (w_valid && w_ready) begin
            wa_log.push_back(w_addr);
            wd_log.push_back(w_data);
            wr_cyc.push_back(cyc);
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
         prev_rv   = r_avalid;
         prev_racc = r_avalid && r_aready;
         prev_ra   = r_addr;
         prev_wv   = w_valid;
         prev_wacc = w_valid && w_ready;
         prev_wa   = w_addr;
         prev_wd   = w_data;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      rd_log.delete();
      wa_log.delete();
      wd_log.delete();
      wr_cyc.delete();
      n_done = 0;
      viol   = 0;
   endtask

   // 0: always ready, 1: random, 2: write stall 10 cycles, 3: read grant 1,0,0,1
   task automatic drive_ready(input int mode, input int i);
      case (mode)
         1: begin
            r_aready = ($urandom_range(0, 3) != 0);
            w_ready  = ($urandom_range(0, 2) != 0);
         end
         2: begin
            r_aready = 1'b1;
            w_ready  = (i >= 10);
         end
         3: begin
            r_aready = ((i % 4) == 0) || ((i % 4) == 3);
            w_ready  = 1'b1;
         end
         default: begin
            r_aready = 1'b1;
            w_ready  = 1'b1;
         end
      endcase
   endtask

   int copy_id = 0;

   task automatic run_copy(input int s, input int d, input int l, input int mode);
      int    bp_reads;
      string t;
      bp_reads = -1;
      copy_id++;
      t = $sformatf("c%0d", copy_id);
      clear_logs();
      @(negedge clk);
      src_base = AW'(s);
      dst_base = AW'(d);
      len      = (AW + 1)'(l);
      start    = 1'b1;
      drive_ready(mode, 0);
      for (int i = 1; i < 3000; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start    = 1'b0;
            src_base = AW'($urandom);
            dst_base = AW'($urandom);
            len      = (AW + 1)'($urandom);
         end
         if (mode == 2 && i == 10) bp_reads = rd_log.size();
         if (n_done != 0) break;
         drive_ready(mode, i);
      end
      repeat (3) @(negedge clk);
      chk({t, "_done_cnt"}, n_done, 1);
      chk({t, "_viol"}, viol, 0);
      chk({t, "_busy_end"}, busy, 0);
      chk({t, "_n_rd"}, rd_log.size(), l);
      chk({t, "_n_wr"}, wa_log.size(), l);
      for (int k = 0; k < l && k < rd_log.size(); k++)
         chk($sformatf("%s_raddr%0d", t, k), rd_log[k], (s + k) % NW);
      for (int k = 0; k < l && k < wa_log.size(); k++) begin
         chk($sformatf("%s_waddr%0d", t, k), wa_log[k], (d + k) % NW);
         chk($sformatf("%s_wdata%0d", t, k), wd_log[k], src_mem[(s + k) % NW]);
      end
      if (mode == 0) begin
         if (l == 0) chk({t, "_done_lat"}, done_cyc - start_cyc, 1);
         else if (wr_cyc.size() == l) begin
            chk({t, "_first_wr"}, wr_cyc[0] - start_cyc, DL + 2);
            chk({t, "_burst"}, wr_cyc[l-1] - wr_cyc[0], l - 1);
            chk({t, "_done_pos"}, done_cyc - wr_cyc[l-1], 1);
         end
      end
      if (mode == 2 && l > 0) chk({t, "_bp_credits"}, bp_reads, (l < FD) ? l : FD);
   endtask

   task automatic reset_mid_copy();
      clear_logs();
      @(negedge clk);
      src_base = 4'd4;
      dst_base = 4'd11;
      len      = 5'd8;
      start    = 1'b1;
      drive_ready(0, 0);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 200 && wa_log.size() < 2; i++) @(negedge clk);
      chk("rst_two_wr", wa_log.size(), 2);
      rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ravalid", r_avalid, 0);
      chk("rst_wvalid", w_valid, 0);
      chk("rst_raddr", r_addr, 0);
      chk("rst_waddr", w_addr, 0);
      chk("rst_wdata", w_data, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("rst_no_done", n_done, 0);
      chk("rst_idle_busy", busy, 0);
      chk("rst_idle_viol", viol, 0);
   endtask

   initial begin
      for (int i = 0; i < NW; i++) src_mem[i] = $urandom;
      repeat (3) @(negedge clk);
      chk("init_busy", busy, 0);
      chk("init_done", done, 0);
      chk("init_ravalid", r_avalid, 0);
      chk("init_wvalid", w_valid, 0);
      chk("init_raddr", r_addr, 0);
      chk("init_waddr", w_addr, 0);
      chk("init_wdata", w_data, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_copy(2, 9, 4, 0);
      run_copy(14, 15, 3, 0);
      run_copy(0, 5, 8, 2);
      run_copy(3, 7, 6, 3);
      run_copy(5, 5, 0, 0);
      run_copy(0, 0, 16, 0);
      run_copy(7, 1, 16, 1);
      reset_mid_copy();
      run_copy(4, 11, 8, 0);
      for (int r = 0; r < 12; r++)
         run_copy($urandom_range(0, NW - 1), $urandom_range(0, NW - 1),
                  $urandom_range(0, NW), $urandom_range(0, 3));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the word width of the memory data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning the word address width; the memory holds 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter DATA_LAT, default 1, meaning the memory read latency in cycles from read acceptance to r_dvalid; legal values are 1 or more.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning the read-data buffer depth; legal values are at least DATA_LAT+1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit: copy request, sampled only in IDLE.
REQ-008 SHALL have ports src_base and dst_base, input, ADDR_WIDTH bits each: source and destination start word addresses.
REQ-009 SHALL have port len, input, ADDR_WIDTH+1 bits: word count, range 0 to 2^ADDR_WIDTH.
REQ-010 SHALL have port busy, output, 1 bit: high while a copy is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have read-initiator ports r_addr (output, ADDR_WIDTH), r_avalid (output, 1), r_aready (input, 1), r_dvalid (input, 1) and r_data (input, DATA_WIDTH).
REQ-013 SHALL have write-initiator ports w_addr (output, ADDR_WIDTH), w_data (output, DATA_WIDTH), w_valid (output, 1) and w_ready (input, 1).

Function
REQ-014 SHALL implement an FSM with states IDLE and RUN.
REQ-015 SHALL move IDLE->RUN when start=1 and len!=0, latching src_base, dst_base and len; start and all inputs SHALL be ignored while busy=1.
REQ-016 SHALL, on start=1 with len=0, stay in IDLE and pulse done on the next cycle without issuing any read or write.
REQ-017 SHALL treat a read as accepted on a cycle with r_avalid=1 and r_aready=1, and a write as accepted on a cycle with w_valid=1 and w_ready=1; r_aready and w_ready may depend combinationally on the valids.
REQ-018 SHALL hold r_avalid high, with r_addr stable, until the read is accepted; likewise w_valid with w_addr and w_data until the write is accepted.
REQ-019 SHALL issue reads at src_base, src_base+1, and so on, up to len reads, with address arithmetic modulo 2^ADDR_WIDTH.
REQ-020 SHALL assert r_avalid only while reads remain and outstanding reads plus FIFO occupancy is less than FIFO_DEPTH (credit rule), so the FIFO never overflows.
REQ-021 SHALL push r_data into the FIFO on every cycle with r_dvalid=1 and at least one read outstanding; r_dvalid with no read outstanding SHALL be ignored.
REQ-022 SHALL drive w_valid=1 whenever the FIFO is non-empty in RUN, with w_data equal to the FIFO head and w_addr equal to dst_base plus the number of writes already accepted, modulo 2^ADDR_WIDTH.
REQ-023 SHALL pop the FIFO on write acceptance; a push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-024 SHALL return RUN->IDLE on the cycle after the len-th write is accepted, with done=1 for exactly that one cycle and busy=0 from that cycle on.
REQ-025 SHALL keep busy=1 from the cycle after start is accepted through the final write acceptance.
REQ-026 SHALL, with r_aready=1 and w_ready=1 held constant, reach r_avalid=1 one cycle after start and w_valid=1 DATA_LAT+1 cycles after the first read acceptance.
REQ-027 SHALL, under the same conditions, sustain one word per cycle.
REQ-028 SHALL preserve data order: the k-th word read SHALL be the k-th word written.
REQ-029 SHALL drive r_avalid=0 and w_valid=0 in IDLE.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force: state IDLE, busy=0, done=0, r_avalid=0, w_valid=0, r_addr=0, w_addr=0, w_data=0, FIFO empty, all counters 0.
REQ-031 SHALL, on reset asserted mid-copy, abandon the copy without a done pulse; read data returning after reset release SHALL be ignored per REQ-021.
REQ-032 SHALL release reset synchronously to clk in effect, so that the first state change occurs on a rising edge with rst_n=1.

Verification
REQ-033 SHALL cover a basic copy: src_base=2, dst_base=9, len=4, r_aready=w_ready=1, DATA_LAT=1 -> writes to 9,10,11,12 in consecutive cycles carrying mem[2..5], and one done pulse.
REQ-034 SHALL cover wrap-around: ADDR_WIDTH=4, src_base=14, dst_base=15, len=3 -> reads at 14,15,0 and writes at 15,0,1.
REQ-035 SHALL cover back-pressure: w_ready=0 for 10 cycles with len=8 -> r_avalid drops after 4 credits are used, no word is lost, and all 8 writes complete in order.
REQ-036 SHALL cover read-grant stalls: r_aready toggled 1,0,0,1 -> r_addr is held stable across the stall and no read address is duplicated or skipped.
REQ-037 SHALL cover len=0 and len=16: len=0 -> done one cycle after start with zero accesses; len=16 -> all 16 words copied.
REQ-038 SHALL cover reset mid-copy: rst_n pulsed low after 2 writes of len=8 -> outputs go immediately to reset values, no done pulse, and a new start copies correctly.
